mult_datapath: RTL and testbench

- Register/arithmetic datapath for the 8-bit signed add-shift multiplier. Sits directly downstream of the multiplier sequencer and executes that unit's one-hot-ish strobes (Clr_ld, Add, Sub, Shift) on the X:A:B register chain.
- Feeds M (current multiplier LSB) back to the sequencer.
- Exposes Aval/Bval/X for the hex display drivers. After a full sequence, the 16-bit product is A:B.

---
 rtl/mult_datapath_if.sv | 28 ++
 rtl/mult_datapath.sv | 75 +++++++
 tb/tb_mult_datapath.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mult_datapath_if.sv
// Strobe/result bundle between the multiplier sequencer and its datapath.
// Sequencer drives S and the strobes; datapath returns M, A, B, X, count, Err.
interface mult_datapath_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic [WIDTH-1:0] S;
   logic             Clr_ld;
   logic             Add;
   logic             Sub;
   logic             Shift;
   logic             M;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             X;
   logic [CNT_W-1:0] Shift_cnt;
   logic             Err;

   modport master (
      output S, Clr_ld, Add, Sub, Shift,
      input  M, Aval, Bval, X, Shift_cnt, Err
   );

   modport slave (
      input  S, Clr_ld, Add, Sub, Shift,
      output M, Aval, Bval, X, Shift_cnt, Err
   );
endinterface

// File: rtl/mult_datapath.sv
// X:A:B register chain of the signed add-shift multiplier.
// Ports: Clk, Reset (sync, active-low), dp (slave: strobes in, regs out).
module mult_datapath #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   mult_datapath_if.slave dp
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             x_q, x_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // One 9-bit adder; Sub inverts the operand and injects carry-in.
   logic [WIDTH:0] opnd;
   logic [WIDTH:0] sum;

   assign opnd = {dp.S[WIDTH-1], dp.S} ^ {(WIDTH+1){dp.Sub}};
   assign sum  = {a_q[WIDTH-1], a_q} + opnd
               + {{WIDTH{1'b0}}, dp.Sub};

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      x_d   = x_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (dp.Clr_ld) begin
         a_d   = '0;
         x_d   = 1'b0;
         b_d   = dp.S;
         cnt_d = '0;
         err_d = 1'b0;
      end else if (dp.Sub || dp.Add) begin
         // Shift alongside arithmetic is dropped.
         a_d = sum[WIDTH-1:0];
         x_d = sum[WIDTH];
         if (dp.Sub && dp.Add)
            err_d = 1'b1;
      end else if (dp.Shift) begin
         a_d = {x_q, a_q[WIDTH-1:1]};
         b_d = {a_q[0], b_q[WIDTH-1:1]};
         if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         a_q   <= '0;
         b_q   <= '0;
         x_q   <= 1'b0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         x_q   <= x_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign dp.M         = b_q[0];
   assign dp.Aval      = a_q;
   assign dp.Bval      = b_q;
   assign dp.X         = x_q;
   assign dp.Shift_cnt = cnt_q;
   assign dp.Err       = err_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Randomized and directed bench for mult_datapath.
// Reference model: signed integer arithmetic on a 17-bit X:A:B chain.
module tb_mult_datapath;

   logic Clk;
   logic Reset;
   int   n_run;
   int   n_fail;

   mult_datapath_if #(.WIDTH(8), .CNT_W(4)) bus ();

   mult_datapath #(.WIDTH(8), .CNT_W(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .dp    (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [7:0] ma, mb;
   logic       mx, merr;
   int         mcnt;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_A"}, 32'(bus.Aval), 32'(ma));
      check({tag, "_B"}, 32'(bus.Bval), 32'(mb));
      check({tag, "_X"}, 32'(bus.X), 32'(mx));
      check({tag, "_M"}, 32'(bus.M), 32'(mb[0]));
      check({tag, "_cnt"}, 32'(bus.Shift_cnt), 32'(mcnt));
      check({tag, "_err"}, 32'(bus.Err), 32'(merr));
   endtask

   // Model: apply one cycle's action from the rules, priority order.
   task automatic model(input logic rst, clr, add, sub, shf,
                        input logic [7:0] s);
      int r;
      logic signed [16:0] ch;
      if (!rst) begin
         ma = 0; mb = 0; mx = 0; mcnt = 0; merr = 0;
      end else if (clr) begin
         ma = 0; mx = 0; mb = s; mcnt = 0; merr = 0;
      end else if (sub || add) begin
         if (sub) r = int'($signed(ma)) - int'($signed(s));
         else     r = int'($signed(ma)) + int'($signed(s));
         ma = r[7:0];
         mx = r[8];
         if (sub && add) merr = 1;
      end else if (shf) begin
         ch = {mx, ma, mb};
         ch = ch >>> 1;
         ma = ch[15:8];
         mb = ch[7:0];
         if (mcnt < 15) mcnt++;
      end
   endtask

   task automatic step(input logic rst, clr, add, sub, shf,
                       input logic [7:0] s);
      Reset      = rst;
      bus.Clr_ld = clr;
      bus.Add    = add;
      bus.Sub    = sub;
      bus.Shift  = shf;
      bus.S      = s;
      model(rst, clr, add, sub, shf, s);
      @(posedge Clk);
      #1;
      Reset      = 1'b1;
      bus.Clr_ld = 1'b0;
      bus.Add    = 1'b0;
      bus.Sub    = 1'b0;
      bus.Shift  = 1'b0;
      bus.S      = 8'($urandom);
   endtask

   task automatic multiply(input logic [7:0] mcand,
                           input logic [7:0] mplier,
                           input string tag);
      logic [15:0] prod;
      step(1, 1, 0, 0, 0, mplier);
      for (int i = 0; i < 8; i++) begin
         if (mb[0])
            step(1, 0, i < 7, i == 7, 0, mcand);
         step(1, 0, 0, 0, 1, mcand);
      end
      prod = 16'(int'($signed(mcand)) * int'($signed(mplier)));
      check({tag, "_prod"}, 32'({bus.Aval, bus.Bval}), 32'(prod));
      check_all(tag);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      Reset  = 1'b1;
      bus.S = 0; bus.Clr_ld = 0; bus.Add = 0;
      bus.Sub = 0; bus.Shift = 0;

      // Reset with all strobes high
      step(0, 1, 1, 1, 1, 8'hFF);
      step(0, 1, 1, 1, 1, 8'hFF);
      check("rst_A", 32'(bus.Aval), 0);
      check("rst_B", 32'(bus.Bval), 0);
      check("rst_M", 32'(bus.M), 0);
      check_all("rst");

      // Load wins over Add
      step(1, 1, 1, 0, 0, 8'h05);
      check("ld_B", 32'(bus.Bval), 32'h05);
      check("ld_M", 32'(bus.M), 1);
      check("ld_A", 32'(bus.Aval), 0);

      // Add chain
      step(1, 0, 1, 0, 0, 8'h7F);
      check("add1_A", 32'(bus.Aval), 32'h7F);
      check("add1_X", 32'(bus.X), 0);
      step(1, 0, 1, 0, 0, 8'h7F);
      check("add2_A", 32'(bus.Aval), 32'hFE);
      check("add2_X", 32'(bus.X), 0);
      step(1, 0, 1, 0, 0, 8'h80);
      check("add3_A", 32'(bus.Aval), 32'h7E);
      check("add3_X", 32'(bus.X), 1);
      check_all("add3");

      // Shift from X=1 A=81 B=02
      step(1, 1, 0, 0, 0, 8'h02);
      step(1, 0, 1, 0, 0, 8'h81);
      step(1, 0, 0, 0, 1, 8'h00);
      check("shf_A", 32'(bus.Aval), 32'hC0);
      check("shf_B", 32'(bus.Bval), 32'h81);
      check("shf_X", 32'(bus.X), 1);
      check("shf_cnt", 32'(bus.Shift_cnt), 1);

      // Full multiplies
      multiply(8'h07, 8'hFD, "m7xn3");
      check("m7xn3_AB", 32'({bus.Aval, bus.Bval}), 32'hFFEB);
      check("m7xn3_X", 32'(bus.X), 1);
      check("m7xn3_cnt", 32'(bus.Shift_cnt), 8);
      multiply(8'hFD, 8'h07, "mn3x7");
      check("mn3x7_AB", 32'({bus.Aval, bus.Bval}), 32'hFFEB);
      multiply(8'h80, 8'h80, "mmin");
      for (int i = 0; i < 20; i++)
         multiply(8'($urandom), 8'($urandom), "mrand");

      // Add+Sub -> Sub and sticky Err
      step(1, 1, 0, 0, 0, 8'h00);
      step(1, 0, 1, 0, 0, 8'h10);
      step(1, 0, 1, 1, 0, 8'h01);
      check("as_A", 32'(bus.Aval), 32'h0F);
      check("as_err", 32'(bus.Err), 1);
      step(1, 0, 0, 0, 1, 8'h00);
      step(1, 0, 1, 0, 0, 8'h03);
      check("as_hold", 32'(bus.Err), 1);
      step(1, 1, 0, 0, 0, 8'h3C);
      check("as_clr", 32'(bus.Err), 0);

      // Add+Shift -> Add only
      step(1, 0, 1, 0, 1, 8'h01);
      check("ash_A", 32'(bus.Aval), 32'h01);
      check("ash_B", 32'(bus.Bval), 32'h3C);
      check("ash_cnt", 32'(bus.Shift_cnt), 0);

      // Saturation of the shift counter
      for (int i = 0; i < 18; i++)
         step(1, 0, 0, 0, 1, 8'h00);
      check("sat_cnt", 32'(bus.Shift_cnt), 15);

      // Random strobes against the model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 31) != 0,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 0,
              8'($urandom));
         check_all("rnd");
      end

      // Reset mid-sequence
      step(1, 0, 1, 0, 0, 8'h55);
      step(0, 0, 1, 0, 1, 8'h55);
      check_all("rst_mid");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
